fb_read_arbiter: RTL
====================

# fb_read_arbiter

Shares the frame buffer's single read port (port b) between the VGA playback path and the image-processing pipeline. It replaces the static select on the read address with a sequenced owner: shared mode with video priority, or exclusive processing mode bracketed by start/done pulses. Read data is returned to whichever requester issued the read, after the buffer's read latency. The block sits between `frame_buffer` port b, `video_playback` and `image_processing`, all in the 25 MHz domain.

## Interface
- `ADDR_W`, 19, frame buffer address width (640×480 words)
- `DATA_W`, 12, pixel width (RGB444)
- `RD_LAT`, 1, frame buffer read latency in cycles; legal 1..3
- `clk_25mhz  in  1  pixel/system clock; all logic on rising edge`
- `resetn  in  1  asynchronous, active-low reset`
- `excl_start  in  1  one-cycle pulse: request exclusive processing ownership`
- `excl_done  in  1  one-cycle pulse: processing finished, return to shared`
- `vid_req  in  1  video read request, any cycle`
- `vid_addr  in  ADDR_W  video read address`
- `vid_rvalid  out  1  video read data valid`
- `vid_rdata  out  DATA_W  video read data`
- `vid_blank  out  1  with vid_rvalid: data suppressed (exclusive mode)`
- `proc_req  in  1  processing read request; held until granted`
- `proc_addr  in  ADDR_W  processing read address, stable while proc_req high`
- `proc_gnt  out  1  processing request accepted this cycle`
- `proc_rvalid  out  1  processing read data valid`
- `proc_rdata  out  DATA_W  processing read data`
- `fb_enb  out  1  frame buffer port-b enable`
- `fb_addrb  out  ADDR_W  frame buffer port-b address`
- `fb_doutb  in  DATA_W  frame buffer port-b data`
- `owner  out  2  current state encoding, for LED/debug`

## Operation
- States: SHARED (0), DRAIN_X (1), EXCL (2), DRAIN_S (3).
- SHARED: `vid_req` always wins; `proc_gnt = proc_req & ~vid_req`. `fb_addrb` is the winner's address, `fb_enb` = any grant.
- `excl_start` in SHARED -> DRAIN_X. In DRAIN_X, video is still served and processing is not granted. After `RD_LAT` cycles (down-counter) -> EXCL.
- EXCL: `proc_gnt = proc_req`; video never touches the port. Each `vid_req` still produces `vid_rvalid` `RD_LAT` cycles later, with `vid_rdata` = 0 and `vid_blank` = 1, so VGA timing is unaffected.
- `excl_done` in EXCL -> DRAIN_S. DRAIN_S grants no processing reads, serves video blanked, and after `RD_LAT` cycles -> SHARED.
- Return routing: a tag shift register `RD_LAT` deep carries {vid_issued, vid_blanked, proc_issued}. `*_rvalid` come from the tail. `vid_rdata`/`proc_rdata` = `fb_doutb`, gated to 0 when the matching valid is low.
- Boundary rules:
  - `excl_start` outside SHARED sets a pending flag, consumed on the next entry to SHARED.
  - `excl_done` outside EXCL is ignored.
  - `excl_start` and `excl_done` in the same cycle: in SHARED, start wins; in EXCL, done wins.
  - In-flight reads always complete to their original requester across state changes.
  - Address wrap: none. Addresses are passed through unchecked.

## Timing
- Grant and `fb_addrb`/`fb_enb` are combinational from request and state (same cycle).
- Read data is valid exactly `RD_LAT` cycles after grant. Throughput is 1 read/cycle total.
- In SHARED with `vid_req` held continuously, processing starvation is permitted. It is bounded in practice by the blanking intervals.
- Reset values:
  - state SHARED, `owner` = 0, counter = 0, pending = 0, tag pipe cleared.
  - all `*_rvalid`, `*_rdata`, `vid_blank`, `proc_gnt`, `fb_enb`, `fb_addrb` = 0.
- Reset asserted mid-operation drops in-flight tags. No stale `rvalid` appears after release.

## Configuration
- `FB_ARB_STATS_EN` defined adds two saturating 32-bit outputs, both cleared by reset:
  - `stat_proc_grants`: count of `proc_gnt` cycles.
  - `stat_vid_blanked`: count of blanked video returns.
- `FB_ARB_STATS_EN` undefined: ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package `fb_pkg`: state enum (`FBA_SHARED`, `FBA_DRAIN_X`, `FBA_EXCL`, `FBA_DRAIN_S`), `FB_ADDR_W`, `FB_DATA_W`, tag struct type.
- One sub-module, `fb_rd_tag_pipe`: a parameterised `RD_LAT`-deep tag shift register with async reset.

## Test plan
- Reset, SHARED; `vid_req`=1, `vid_addr`=0x00010 continuously; `proc_req`=1 -> `proc_gnt` stays 0. `vid_rvalid` follows each request `RD_LAT` later, with `vid_rdata` = memory[0x00010].
- SHARED; `vid_req` low, `proc_req`=1, `proc_addr`=0x4B000-1 -> `proc_gnt`=1 same cycle. `proc_rvalid` `RD_LAT` later with the stored word.
- `excl_start` pulse with `RD_LAT`=2 -> `owner` 1 for 2 cycles, then 2. Subsequent `vid_req` returns `vid_blank`=1 with data 0; `proc_gnt` follows `proc_req` every cycle.
- In EXCL, `excl_start` and `excl_done` in the same cycle -> DRAIN_S, then SHARED after `RD_LAT` cycles. Pending flag stays 0.
- `excl_start` during DRAIN_S -> SHARED for 1 cycle, then DRAIN_X automatically.
- `resetn` low while a processing read is in flight -> no `proc_rvalid` after release; all outputs 0. With `FB_ARB_STATS_EN`, counters read 0.

Source files
------------

// File: rtl/fb_read_arbiter_pkg.sv
// Shared types for the frame-buffer read-port arbiter: owner states,
// default widths and the read-return tag carried alongside each read.
package fb_pkg;

    localparam int FB_ADDR_W = 19;
    localparam int FB_DATA_W = 12;

    typedef enum logic [1:0] {
        FBA_SHARED  = 2'd0,
        FBA_DRAIN_X = 2'd1,
        FBA_EXCL    = 2'd2,
        FBA_DRAIN_S = 2'd3
    } fba_state_t;

    typedef struct packed {
        logic vid_issued;
        logic vid_blanked;
        logic proc_issued;
    } fb_tag_t;

    localparam fb_tag_t FB_TAG_IDLE = '0;

    // Drain counter load value: the counter runs lat-1 .. 0 so a drain
    // state lasts exactly lat cycles.
    function automatic logic [1:0] drain_load(input int lat);
        return 2'(lat - 1);
    endfunction

endpackage

// File: rtl/fb_read_arbiter_if.sv
// Read-side bus between the arbiter, its two requesters and frame-buffer
// port b. Modport slave is the arbiter view; master is the environment.
interface fb_read_arbiter_if
    import fb_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DATA_W = FB_DATA_W
) ();

    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_rvalid;
    logic [DATA_W-1:0] vid_rdata;
    logic              vid_blank;

    logic              proc_req;
    logic [ADDR_W-1:0] proc_addr;
    logic              proc_gnt;
    logic              proc_rvalid;
    logic [DATA_W-1:0] proc_rdata;

    logic              fb_enb;
    logic [ADDR_W-1:0] fb_addrb;
    logic [DATA_W-1:0] fb_doutb;

    modport slave (
        input  vid_req, vid_addr,
        input  proc_req, proc_addr,
        input  fb_doutb,
        output vid_rvalid, vid_rdata, vid_blank,
        output proc_gnt, proc_rvalid, proc_rdata,
        output fb_enb, fb_addrb
    );

    modport master (
        output vid_req, vid_addr,
        output proc_req, proc_addr,
        output fb_doutb,
        input  vid_rvalid, vid_rdata, vid_blank,
        input  proc_gnt, proc_rvalid, proc_rdata,
        input  fb_enb, fb_addrb
    );

endinterface

// File: rtl/fb_rd_tag_pipe.sv
// DEPTH-deep shift register carrying the read-return tag so that data
// coming out of the frame buffer is routed to the requester that issued it.
// Ports: clk, resetn (async, active low), issue (tag of this cycle's read),
// retire (tag of the read whose data is on fb_doutb now).
module fb_rd_tag_pipe
    import fb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    clk,
    input  logic    resetn,
    input  fb_tag_t issue,
    output fb_tag_t retire
);

    fb_tag_t stage [DEPTH];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= FB_TAG_IDLE;
            end
        end else begin
            stage[0] <= issue;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign retire = stage[DEPTH-1];

endmodule

// File: rtl/fb_read_arbiter.sv
// Arbitrates frame-buffer port b between video playback and image processing.
// Shared mode gives video strict priority; exclusive mode (bracketed by
// excl_start/excl_done pulses, with RD_LAT-cycle drains either side) hands
// the port to processing and returns blanked zeros to video.
// Ports: clk_25mhz, resetn (async, active low), excl_start, excl_done,
// owner (state for LEDs), bus (fb_read_arbiter_if.slave: requests, returns,
// fb_enb/fb_addrb/fb_doutb). Define FB_ARB_STATS_EN to add the saturating
// counters stat_proc_grants and stat_vid_blanked.
module fb_read_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DATA_W = FB_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic        clk_25mhz,
    input  logic        resetn,
    input  logic        excl_start,
    input  logic        excl_done,
    output logic [1:0]  owner,
`ifdef FB_ARB_STATS_EN
    output logic [31:0] stat_proc_grants,
    output logic [31:0] stat_vid_blanked,
`endif
    fb_read_arbiter_if.slave bus
);

    localparam logic [1:0] LAT_LOAD = drain_load(RD_LAT);

    fba_state_t state;
    fba_state_t state_nxt;
    logic [1:0] cnt;
    logic [1:0] cnt_nxt;
    logic       pending;
    logic       pending_nxt;

    logic       vid_gnt;
    logic       proc_gnt;
    logic       vid_blanked;

    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] vid_data;
    logic [DATA_W-1:0] proc_data;

    fb_tag_t issue_tag;
    fb_tag_t retire_tag;

    always_ff @(posedge clk_25mhz or negedge resetn) begin
        if (!resetn) begin
            state   <= FBA_SHARED;
            cnt     <= 2'd0;
            pending <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pending <= pending_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pending_nxt = pending;
        vid_gnt     = 1'b0;
        proc_gnt    = 1'b0;
        vid_blanked = 1'b0;
        unique case (state)
            FBA_SHARED: begin
                vid_gnt  = bus.vid_req;
                proc_gnt = bus.proc_req & ~bus.vid_req;
                // A start deferred from another state is honoured here,
                // one cycle after arriving back in SHARED.
                if (excl_start || pending) begin
                    state_nxt   = FBA_DRAIN_X;
                    cnt_nxt     = LAT_LOAD;
                    pending_nxt = 1'b0;
                end
            end
            FBA_DRAIN_X: begin
                vid_gnt = bus.vid_req;
                if (excl_start) begin
                    pending_nxt = 1'b1;
                end
                if (cnt == 2'd0) begin
                    state_nxt = FBA_EXCL;
                end else begin
                    cnt_nxt = cnt - 2'd1;
                end
            end
            FBA_EXCL: begin
                proc_gnt    = bus.proc_req;
                vid_blanked = bus.vid_req;
                // done beats a simultaneous start; that start is dropped
                if (excl_done) begin
                    state_nxt = FBA_DRAIN_S;
                    cnt_nxt   = LAT_LOAD;
                end else if (excl_start) begin
                    pending_nxt = 1'b1;
                end
            end
            FBA_DRAIN_S: begin
                vid_blanked = bus.vid_req;
                if (excl_start) begin
                    pending_nxt = 1'b1;
                end
                if (cnt == 2'd0) begin
                    state_nxt = FBA_SHARED;
                end else begin
                    cnt_nxt = cnt - 2'd1;
                end
            end
            default: begin
                state_nxt = FBA_SHARED;
            end
        endcase
    end

    // Every video request returns a valid RD_LAT later; only granted ones
    // actually used the port, the rest come back blanked.
    assign issue_tag = '{
        vid_issued:  bus.vid_req,
        vid_blanked: vid_blanked,
        proc_issued: proc_gnt
    };

    fb_rd_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_tag_pipe (
        .clk    (clk_25mhz),
        .resetn (resetn),
        .issue  (issue_tag),
        .retire (retire_tag)
    );

    assign addr_sel = vid_gnt  ? bus.vid_addr  :
                      proc_gnt ? bus.proc_addr : '0;

    assign vid_data  = (retire_tag.vid_issued && !retire_tag.vid_blanked)
                     ? bus.fb_doutb : '0;
    assign proc_data = retire_tag.proc_issued ? bus.fb_doutb : '0;

    assign bus.proc_gnt    = proc_gnt;
    assign bus.fb_enb      = vid_gnt | proc_gnt;
    assign bus.fb_addrb    = addr_sel;
    assign bus.vid_rvalid  = retire_tag.vid_issued;
    assign bus.vid_blank   = retire_tag.vid_issued & retire_tag.vid_blanked;
    assign bus.vid_rdata   = vid_data;
    assign bus.proc_rvalid = retire_tag.proc_issued;
    assign bus.proc_rdata  = proc_data;
    assign owner           = state;

`ifdef FB_ARB_STATS_EN
    logic blank_ret;

    assign blank_ret = retire_tag.vid_issued & retire_tag.vid_blanked;

    always_ff @(posedge clk_25mhz or negedge resetn) begin
        if (!resetn) begin
            stat_proc_grants <= '0;
            stat_vid_blanked <= '0;
        end else begin
            if (proc_gnt && stat_proc_grants != '1) begin
                stat_proc_grants <= stat_proc_grants + 32'd1;
            end
            if (blank_ret && stat_vid_blanked != '1) begin
                stat_vid_blanked <= stat_vid_blanked + 32'd1;
            end
        end
    end
`endif

endmodule
